// File: rtl/quadra_out_buf.sv
// rtl/quadra_out_buf.sv - elastic output buffer with credit stall and drop accounting
module quadra_out_buf #(
    parameter int DW       = 16,
    parameter int DEPTH    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              y_in,
    input  logic                       y_in_dv,
    output logic [DW-1:0]              m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       x_stall,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic [7:0]                 drop_cnt,
    input  logic                       ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
    localparam logic [PW-1:0] STALL_TH = PW'(DEPTH - PIPE_LAT - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          x_stall_q;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic push, pop, full, accept, drop;

    assign full    = (level_q == FULL_LVL);
    assign m_valid = (level_q != '0);
    assign pop     = m_valid & m_ready;
    assign push    = y_in_dv;
    // A full buffer still accepts when the same edge pops, since that frees the slot.
    assign accept  = push & (~full | pop);
    assign drop    = push & full & ~pop;

    // Gate the head so stale or never-written entries do not leak out while empty.
    assign m_data   = m_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign level    = level_q;
    assign x_stall  = x_stall_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

    // Next-state for pointers, occupancy and drop accounting.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (accept) wr_ptr_d = wr_ptr_q + ONE;
        if (pop)    rd_ptr_d = rd_ptr_q + ONE;
        if (accept && !pop)      level_d = level_q + ONE;
        else if (!accept && pop) level_d = level_q - ONE;
        // A drop on the same edge as a clear wins and restarts the count at one.
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_clr)                  drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // Control state; the stall threshold is one lower to cover this register's delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            x_stall_q  <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            x_stall_q  <= (level_d >= STALL_TH);
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage array; written only for accepted beats so y_in is ignored while dv is low.
    always_ff @(posedge clk) begin
        if (!rst && accept) mem_q[wr_ptr_q[AW-1:0]] <= y_in;
    end
endmodule

// File: tb/tb_quadra_out_buf.sv
// tb/tb_quadra_out_buf.sv - self-checking bench for quadra_out_buf
module tb_quadra_out_buf;
    localparam int DW       = 8;
    localparam int DEPTH    = 8;
    localparam int PIPE_LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] y_in = '0;
    logic          y_in_dv = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          x_stall;
    logic [3:0]    level;
    logic          ovf;
    logic [7:0]    drop_cnt;
    logic          ovf_clr = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] mq[$];
    int m_ovf = 0;
    int m_cnt = 0;
    int m_stall = 0;

    quadra_out_buf #(.DW(DW), .DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .y_in_dv(y_in_dv),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .x_stall(x_stall), .level(level), .ovf(ovf), .drop_cnt(drop_cnt),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the queue model, compare every output.
    task automatic step(input logic r, input logic dv, input logic [DW-1:0] d,
                        input logic rdy, input logic clr);
        bit pop, full, drop;
        logic [DW-1:0] tmp;
        rst = r; y_in_dv = dv; y_in = d; m_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        if (r) begin
            mq.delete(); m_ovf = 0; m_cnt = 0; m_stall = 0;
        end else begin
            pop  = (mq.size() > 0) && rdy;
            full = (mq.size() == DEPTH);
            drop = 1'b0;
            if (pop) tmp = mq.pop_front();
            if (dv) begin
                if (!full || pop) mq.push_back(d);
                else drop = 1'b1;
            end
            if (drop) begin
                m_ovf = 1;
                m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (clr) begin
                m_ovf = 0; m_cnt = 0;
            end
            m_stall = (mq.size() >= DEPTH - PIPE_LAT - 1) ? 1 : 0;
        end
        #1;
        chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("m_data", 32'(m_data), 32'(mq[0]));
        chk("level", 32'(level), 32'(mq.size()));
        chk("x_stall", 32'(x_stall), 32'(m_stall));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    endtask

    initial begin
        logic [2:0] pipe;
        logic xdv;

        // Reset held two cycles with dv asserted.
        step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h5B, 1'b1, 1'b0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_valid", 32'(m_valid), 32'd0);

        // Pass-through with the consumer always ready.
        step(1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
        chk("pt_first", 32'(m_data), 32'h11);
        step(1'b0, 1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        chk("pt_level", 32'(level), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // X on y_in while dv is low must not reach the head.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 'x, 1'b1, 1'b0);

        // Fill toward stall, then overflow by two.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        chk("stall_at4", 32'(x_stall), 32'd1);
        for (int i = 4; i < 10; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_cnt", 32'(drop_cnt), 32'd2);

        // Push and pop together at full.
        step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_pp_level", 32'(level), 32'd8);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Clear coincident with a full drop.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("clr_drop_ovf", 32'(ovf), 32'd1);

        // Saturation of the drop counter.
        for (int i = 0; i < 260; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
        chk("sat_cnt", 32'(drop_cnt), 32'd255);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset at level 5.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd5);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_rst_head", 32'(m_data), 32'h77);

        // Random traffic, many wraps.
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
                 8'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));

        // A source obeying x_stall through a PIPE_LAT delay line never drops.
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        pipe = '0;
        for (int i = 0; i < 600; i++) begin
            xdv  = !x_stall && ($urandom_range(0, 3) != 0);
            step(1'b0, pipe[2], 8'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
            pipe = {pipe[1:0], xdv};
        end
        chk("obey_no_drop", 32'(drop_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
